// File: rtl/router_ivc_pkg.sv
// Shared types and helpers for the router input-VC buffer.
package router_ivc_pkg;

    localparam int unsigned IVC_FLIT_W   = 32;
    localparam int unsigned IVC_VC_MAX_W = 3;

    function automatic int unsigned vc_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [IVC_VC_MAX_W-1:0] vc;
    } ivc_credit_t;

endpackage

// File: rtl/router_ivc_fifo.sv
// Single-VC FIFO; a push into a full FIFO is accepted only alongside a pop.
module router_ivc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/router_ivc_buffer.sv
// Per-input-port VC buffer: NUM_VC FIFOs, round-robin head selection with grant lock, credits.
// Optional ROUTER_IVC_OVF_CHECK_EN adds a sticky overflow_err flag for dropped writes.
module router_ivc_buffer
    import router_ivc_pkg::*;
#(
    parameter int unsigned FLIT_W = IVC_FLIT_W,
    parameter int unsigned NUM_VC = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned VC_W   = vc_w(NUM_VC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              out_valid,
    output logic [VC_W-1:0]   out_vc,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              out_ready,
    output logic              credit_valid,
    output logic [VC_W-1:0]   credit_vc
`ifdef ROUTER_IVC_OVF_CHECK_EN
    ,
    output logic              overflow_err
`endif
);

    logic [FLIT_W-1:0] fifo_dout [NUM_VC];
    logic [NUM_VC-1:0] fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic [VC_W-1:0] rr_ptr_q, lock_vc_q, cand_vc, sel_vc;
    logic            locked_q, found, handshake, in_range;
    ivc_credit_t     credit_q;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_fifo
        router_ivc_fifo #(
            .WIDTH(FLIT_W),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .push (fifo_push[v]),
            .pop  (fifo_pop[v]),
            .din  (in_flit),
            .dout (fifo_dout[v]),
            .empty(fifo_empty[v]),
            .full (fifo_full[v])
        );
    end

    // First non-empty VC starting at rr_ptr_q.
    always_comb begin
        cand_vc = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!found && !fifo_empty[(int'(rr_ptr_q) + i) % NUM_VC]) begin
                found   = 1'b1;
                cand_vc = VC_W'((int'(rr_ptr_q) + i) % NUM_VC);
            end
        end
    end

    assign sel_vc    = locked_q ? lock_vc_q : cand_vc;
    assign out_valid = ~&fifo_empty;
    assign out_vc    = out_valid ? sel_vc : '0;
    assign out_flit  = out_valid ? fifo_dout[sel_vc] : '0;
    assign handshake = out_valid && out_ready;
    assign in_range  = 32'(in_vc) < NUM_VC;

    always_comb begin
        fifo_push = '0;
        fifo_pop  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            fifo_push[v] = in_valid && in_range && (in_vc == VC_W'(v));
            fifo_pop[v]  = handshake && (sel_vc == VC_W'(v));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            lock_vc_q <= '0;
            locked_q  <= 1'b0;
            credit_q  <= '0;
        end else begin
            credit_q.valid <= handshake;
            credit_q.vc    <= handshake ? IVC_VC_MAX_W'(sel_vc) : '0;
            if (handshake) begin
                locked_q <= 1'b0;
                rr_ptr_q <= VC_W'((int'(sel_vc) + 1) % NUM_VC);
            end else if (out_valid) begin
                locked_q  <= 1'b1;
                lock_vc_q <= sel_vc;
            end
        end
    end

    assign credit_valid = credit_q.valid;
    assign credit_vc    = VC_W'(credit_q.vc);

`ifdef ROUTER_IVC_OVF_CHECK_EN
    logic ovf_q, drop;

    assign drop = (in_valid && !in_range) || |(fifo_push & fifo_full & ~fifo_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end

    assign overflow_err = ovf_q;
`endif

endmodule

// File: tb/tb_router_ivc_buffer.sv
// Directed self-checking bench for router_ivc_buffer (NUM_VC=2, DEPTH=4).
module tb_router_ivc_buffer;

    localparam int unsigned FLIT_W = 32;
    localparam int unsigned VC_W   = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [VC_W-1:0]   in_vc;
    logic [FLIT_W-1:0] in_flit;
    logic              out_valid;
    logic [VC_W-1:0]   out_vc;
    logic [FLIT_W-1:0] out_flit;
    logic              out_ready;
    logic              credit_valid;
    logic [VC_W-1:0]   credit_vc;
`ifdef ROUTER_IVC_OVF_CHECK_EN
    logic              overflow_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_ivc_buffer #(
        .FLIT_W(FLIT_W),
        .NUM_VC(2),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_vc       (in_vc),
        .in_flit     (in_flit),
        .out_valid   (out_valid),
        .out_vc      (out_vc),
        .out_flit    (out_flit),
        .out_ready   (out_ready),
        .credit_valid(credit_valid),
        .credit_vc   (credit_vc)
`ifdef ROUTER_IVC_OVF_CHECK_EN
        ,
        .overflow_err(overflow_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [VC_W-1:0] vc, input logic [31:0] flit);
        in_valid = 1'b1;
        in_vc    = vc;
        in_flit  = flit;
        tick();
        in_valid = 1'b0;
    endtask

    // Offered flit/VC at this moment, then one cycle of out_ready=1 and the resulting credit.
    task automatic pop_expect(input string tag, input logic [VC_W-1:0] vc, input logic [31:0] flit);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_vc"}, 32'(out_vc), 32'(vc));
        check({tag, "_flit"}, out_flit, flit);
        out_ready = 1'b1;
        tick();
        check({tag, "_crv"}, 32'(credit_valid), 32'd1);
        check({tag, "_crvc"}, 32'(credit_vc), 32'(vc));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vc     = '0;
        in_flit   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_vc", 32'(out_vc), 32'd0);
        check("rst_out_flit", out_flit, 32'd0);
        check("rst_credit_valid", 32'(credit_valid), 32'd0);
        check("rst_credit_vc", 32'(credit_vc), 32'd0);
`ifdef ROUTER_IVC_OVF_CHECK_EN
        check("rst_ovf", 32'(overflow_err), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Basic write, pop, credit
        push(1'b1, 32'hA5A5_A5A5);
        pop_expect("basic", 1'b1, 32'hA5A5_A5A5);
        check("basic_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();
        check("basic_cr_once", 32'(credit_valid), 32'd0);

        // Round-robin: rr_ptr is 0 again
        push(1'b0, 32'd1);
        push(1'b0, 32'd2);
        push(1'b1, 32'd3);
        push(1'b1, 32'd4);
        pop_expect("rr0", 1'b0, 32'd1);
        pop_expect("rr1", 1'b1, 32'd3);
        pop_expect("rr2", 1'b0, 32'd2);
        pop_expect("rr3", 1'b1, 32'd4);
        check("rr_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();
        check("rr_cr_done", 32'(credit_valid), 32'd0);

        // Grant lock: VC1 offered and stalled, then VC0 arrives
        push(1'b1, 32'h11);
        check("lock_first_vc", 32'(out_vc), 32'd1);
        push(1'b0, 32'h22);
        check("lock_hold_vc_a", 32'(out_vc), 32'd1);
        tick();
        check("lock_hold_vc_b", 32'(out_vc), 32'd1);
        check("lock_hold_flit", out_flit, 32'h11);
        pop_expect("lock_pop1", 1'b1, 32'h11);
        pop_expect("lock_pop0", 1'b0, 32'h22);
        out_ready = 1'b0;
        tick();

        // Full VC0: push+pop while full is kept, push without pop is dropped
        push(1'b0, 32'h40);
        push(1'b0, 32'h41);
        push(1'b0, 32'h42);
        push(1'b0, 32'h43);
        check("full_head", out_flit, 32'h40);
        in_valid  = 1'b1;
        in_vc     = 1'b0;
        in_flit   = 32'h44;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_swap_cr", 32'(credit_valid), 32'd1);
        check("full_swap_head", out_flit, 32'h41);
        push(1'b0, 32'h45);
        check("full_drop_cr", 32'(credit_valid), 32'd0);
`ifdef ROUTER_IVC_OVF_CHECK_EN
        check("full_ovf", 32'(overflow_err), 32'd1);
`endif
        pop_expect("drain0", 1'b0, 32'h41);
        pop_expect("drain1", 1'b0, 32'h42);
        pop_expect("drain2", 1'b0, 32'h43);
        pop_expect("drain3", 1'b0, 32'h44);
        check("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();

        // Reset mid-stream with a credit in flight
        push(1'b1, 32'h51);
        push(1'b0, 32'h52);
        push(1'b1, 32'h53);
        out_ready = 1'b1;
        tick();
        check("mid_cr_before", 32'(credit_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_credit", 32'(credit_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_credit", 32'(credit_valid), 32'd0);
`ifdef ROUTER_IVC_OVF_CHECK_EN
        check("post_rst_ovf", 32'(overflow_err), 32'd0);
`endif
        out_ready = 1'b0;
        push(1'b0, 32'h60);
        pop_expect("post_rst", 1'b0, 32'h60);
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_ivc_buffer.md
# router_ivc_buffer

Per-input-port virtual-channel buffer for the router slice. It consumes the registered flit stream produced by the input-VC flip-flop stage and stores each flit in one of `NUM_VC` per-VC FIFOs. A round-robin selector presents one head flit at a time to the downstream switch-allocation stage over a valid/ready handshake. Each accepted flit returns one credit to the upstream router.

## Interface
Parameters:
- `FLIT_W`, 32: flit payload width in bits.
- `NUM_VC`, 2: number of virtual channels; 2..8.
- `DEPTH`, 4: entries per VC FIFO; power of two, at least 2.
- `VC_W`, derived as `max(1, $clog2(NUM_VC))`: VC index width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `in_valid`, in, 1: a flit is present this cycle; there is no ready signal (credit-based flow control).
- `in_vc`, in, `VC_W`: target VC of the incoming flit.
- `in_flit`, in, `FLIT_W`: incoming flit payload.
- `out_valid`, out, 1: a head flit is offered downstream.
- `out_vc`, out, `VC_W`: VC of the offered flit.
- `out_flit`, out, `FLIT_W`: the offered flit.
- `out_ready`, in, 1: downstream accepts the flit this cycle.
- `credit_valid`, out, 1: one credit is returned upstream.
- `credit_vc`, out, `VC_W`: VC the credit belongs to.
- `overflow_err`, out, 1: sticky error flag; present only with `ROUTER_IVC_OVF_CHECK_EN`.

## Operation
- **Write:**
  - When `in_valid` is high, `in_flit` is pushed into FIFO `in_vc`.
  - `in_vc >= NUM_VC` is a protocol violation; the flit is dropped.
- **Pop:** a handshake (`out_valid && out_ready`) pops the head of FIFO `out_vc`.
- **Push and pop on the same VC in the same cycle:**
  - Both take effect and the occupancy is unchanged.
  - This applies even when that VC is full, because the pop frees the slot.
- **Write to a full VC without a same-cycle pop on that VC:**
  - The flit is dropped and the FIFO is unchanged.
  - The upstream router is responsible for this never happening.
- **Selection:**
  - `rr_ptr` (`VC_W` bits) holds the starting VC.
  - The candidate is the first non-empty VC scanning `rr_ptr`, `rr_ptr+1`, ... modulo `NUM_VC`.
  - `out_valid` = any VC non-empty.
- **Grant lock:**
  - If `out_valid` is high and `out_ready` is low, the current candidate is registered into `lock_vc` and `locked` is set.
  - While `locked`, `out_vc` = `lock_vc` regardless of new arrivals.
  - `out_vc` and `out_flit` therefore stay stable until the handshake.
  - The handshake clears `locked`.
- **Pointer update:**
  - On each handshake, `rr_ptr` takes the value (granted VC + 1) modulo `NUM_VC`.
  - Otherwise `rr_ptr` holds.
- **Credit:** every handshake produces `credit_valid` = 1 and `credit_vc` = the popped VC, registered for one cycle.
- **Occupancy:**
  - Per-VC count is `$clog2(DEPTH+1)` bits.
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- **Reset values:**
  - All FIFOs empty, `rr_ptr` = 0, `locked` = 0.
  - Outputs: `out_valid` = 0, `credit_valid` = 0, `credit_vc` = 0, `overflow_err` = 0.
  - `out_flit` and `out_vc` read as 0 when nothing is offered.
- **Write-to-output latency:** a flit written at edge N into an empty buffer appears on `out_*` after edge N. There is no same-cycle bypass.
- `out_valid`, `out_vc` and `out_flit` are driven combinationally from registered state only. There is no combinational path from `out_ready` to `out_valid`.
- **Credit latency:** a handshake in cycle N gives `credit_valid` high in cycle N+1, for exactly one cycle per popped flit.
- **Back-to-back pops:** one pop per cycle is sustained, with one credit per cycle.
- **Reset asserted mid-operation:** all contents are discarded immediately. Credits for flits still buffered are not returned; the upstream router resets its credit counters with the same reset.

## Configuration
- **`ROUTER_IVC_OVF_CHECK_EN` defined:**
  - The `overflow_err` port exists.
  - It sets on any dropped write: full VC without a same-cycle pop, or `in_vc` out of range.
  - It stays high until `reset`.
- **Not defined:**
  - The port and its logic are absent.
  - Dropped writes are silent.

## Structure
- **Package `router_ivc_pkg`:**
  - Default `FLIT_W`.
  - Function `vc_w(n)` returning `max(1, $clog2(n))`.
  - Typedef `ivc_credit_t` with fields `valid` and `vc`.
- **Sub-module `router_ivc_fifo`:**
  - Single-VC FIFO with `push`, `pop`, `din`, `dout`, `empty`, `full`.
  - Asynchronous active-high reset.
  - Instantiated `NUM_VC` times in a generate loop.
- The top level holds the round-robin selector, grant lock, credit register and overflow flag.

## Test plan
- **Basic write, pop and credit:** reset, then `in_valid` with `in_vc`=1, flit 0xA5A5A5A5. Required: next cycle `out_valid`=1, `out_vc`=1, `out_flit`=0xA5A5A5A5. Hold `out_ready`=1; the cycle after the handshake shows `credit_valid`=1 and `credit_vc`=1.
- **Round-robin order:** load VC0 with flits 1,2 and VC1 with flits 3,4, then hold `out_ready`=1. Required: pops in order 1,3,2,4 and four credits with VCs 0,1,0,1.
- **Grant lock:** VC1 non-empty, `rr_ptr`=0, `out_ready`=0, then write VC0. Required: `out_vc` stays 1 until the handshake, then VC0 is served next.
- **Full VC with simultaneous pop and push:** fill VC0 to 4 entries. Push and pop VC0 in the same cycle; then push VC0 without a pop. Required: the first push is kept and occupancy stays 4. The second flit is dropped and `overflow_err`=1 (macro on).
- **Reset mid-stream:** with 3 flits buffered, assert `reset` for 1 cycle. Required: `out_valid`=0 and `credit_valid`=0 immediately. After release, no stale flits appear.
